systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder.sv | 247 ++++++++++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Wrapper stage for a 2x2 systolic array with registered PEs. It accepts one
// pair of 2x2 operand matrices A and B and drives them into the array with the
// diagonal skew the array needs. After the array pipeline drains, it captures
// the four accumulators and presents the product matrix C = A*B on a
// valid/ready result port. Only one job is in flight at a time.
//
// Parameters
//   DATA_W        operand element width (must match the array a/b width)
//   ACC_W         result element width, >= 2*DATA_W+1
//   DRAIN_CYCLES  cycles spent in DRAIN before capture, legal range 1..7
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   a_mat, b_mat      {X11,X10,X01,X00}, element X00 in the LSBs
//   a1, a2, b1, b2    registered operand feeds to array rows / columns
//   initialize        registered accumulator clear, high on the first step
//   c1..c4            array accumulators c11, c12, c21, c22
//   res_valid/ready   result handshake
//   res_mat           {C22,C21,C12,C11}, C11 in the LSBs, stable while valid
//   busy              high in any state other than IDLE
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int DATA_W       = 4,
  parameter int ACC_W        = 9,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // operand input port
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*DATA_W-1:0]  a_mat,
  input  logic [4*DATA_W-1:0]  b_mat,
  // array-facing feeds
  output logic [DATA_W-1:0]    a1,
  output logic [DATA_W-1:0]    a2,
  output logic [DATA_W-1:0]    b1,
  output logic [DATA_W-1:0]    b2,
  output logic                 initialize,
  // array accumulators
  input  logic [ACC_W-1:0]     c1,
  input  logic [ACC_W-1:0]     c2,
  input  logic [ACC_W-1:0]     c3,
  input  logic [ACC_W-1:0]     c4,
  // result port
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*ACC_W-1:0]   res_mat,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_RESULT
  } state_e;

  // One cycle's worth of array-facing values.
  typedef struct packed {
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] a2;
    logic [DATA_W-1:0] b1;
    logic [DATA_W-1:0] b2;
    logic              init;
  } feed_t;

  // The step counter is shared by FEED (k = 0..3) and DRAIN
  // (0..DRAIN_CYCLES-1); three bits cover both ranges.
  localparam logic [2:0] FEED_LAST  = 3'd3;
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [4*DATA_W-1:0] a_op_q, a_op_d;
  logic [4*DATA_W-1:0] b_op_q, b_op_d;
  feed_t               feed_q, feed_d;
  logic                res_valid_q, res_valid_d;
  logic [4*ACC_W-1:0]  res_mat_q, res_mat_d;

  logic                accept;
  logic                capture;
  logic [4*DATA_W-1:0] a_src;
  logic [4*DATA_W-1:0] b_src;

  // Skew schedule. Row 2 / column 2 lag row 1 / column 1 by one step so that
  // matching A and B elements meet inside each PE on the same cycle; step 3
  // is an all-zero flush for the PE22 path.
  function automatic feed_t skew(input logic [1:0]          k,
                                 input logic [4*DATA_W-1:0] a,
                                 input logic [4*DATA_W-1:0] b);
    feed_t f;
    f = '0;
    case (k)
      2'd0: begin
        f.a1   = a[0*DATA_W +: DATA_W];   // A00
        f.b1   = b[0*DATA_W +: DATA_W];   // B00
        f.init = 1'b1;
      end
      2'd1: begin
        f.a1 = a[1*DATA_W +: DATA_W];     // A01
        f.b1 = b[2*DATA_W +: DATA_W];     // B10
        f.a2 = a[2*DATA_W +: DATA_W];     // A10
        f.b2 = b[1*DATA_W +: DATA_W];     // B01
      end
      2'd2: begin
        f.a2 = a[3*DATA_W +: DATA_W];     // A11
        f.b2 = b[3*DATA_W +: DATA_W];     // B11
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign capture  = (state_q == S_DRAIN) && (step_q == DRAIN_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from an always_comb gets a default at the top,
  // so no path through the case statement can leave it unassigned and infer
  // a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FEED;
          step_d  = '0;
        end
      end
      S_FEED: begin
        if (step_q == FEED_LAST) begin
          state_d = S_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (capture) begin
          state_d = S_RESULT;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  // The array feeds are registered, so the value computed here is the one for
  // the step the FSM is about to enter. On the acceptance edge the operand
  // registers are still being loaded, so step 0 reads straight from the port.
  always_comb begin
    a_op_d      = a_op_q;
    b_op_d      = b_op_q;
    res_valid_d = res_valid_q;
    res_mat_d   = res_mat_q;

    if (accept) begin
      a_op_d = a_mat;
      b_op_d = b_mat;
    end

    a_src = accept ? a_mat : a_op_q;
    b_src = accept ? b_mat : b_op_q;

    if (state_d == S_FEED) begin
      feed_d = skew(step_d[1:0], a_src, b_src);
    end else begin
      feed_d = '0;
    end

    // By the last DRAIN cycle the PE22 sum has landed; the array only adds
    // zeros from here on, so c1..c4 are final.
    if (capture) begin
      res_mat_d   = {c4, c3, c2, c1};
      res_valid_d = 1'b1;
    end else if ((state_q == S_RESULT) && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_op_q      <= '0;
      b_op_q      <= '0;
      feed_q      <= '0;
      res_valid_q <= 1'b0;
      res_mat_q   <= '0;
    end else begin
      a_op_q      <= a_op_d;
      b_op_q      <= b_op_d;
      feed_q      <= feed_d;
      res_valid_q <= res_valid_d;
      res_mat_q   <= res_mat_d;
    end
  end

  assign a1         = feed_q.a1;
  assign a2         = feed_q.a2;
  assign b1         = feed_q.b1;
  assign b2         = feed_q.b2;
  assign initialize = feed_q.init;
  assign res_valid  = res_valid_q;
  assign res_mat    = res_mat_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_skew_feeder. A behavioural 2x2 systolic array with
// registered PEs is attached to the feeder outputs; expected results are
// plain matrix products, and expected feed values come from the skew table.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int DW = 4;
  localparam int AW = 9;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] a_mat;
  logic [4*DW-1:0] b_mat;
  logic [DW-1:0]   a1, a2, b1, b2;
  logic            initialize;
  logic [AW-1:0]   c1, c2, c3, c4;
  logic            res_valid;
  logic            res_ready;
  logic [4*AW-1:0] res_mat;
  logic            busy;

  systolic_skew_feeder #(
    .DATA_W      (DW),
    .ACC_W       (AW),
    .DRAIN_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .a1        (a1),
    .a2        (a2),
    .b1        (b1),
    .b2        (b2),
    .initialize(initialize),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mat   (res_mat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural 2x2 systolic array: PE11 takes a1/b1, passes a right and b
  // down through one register each; PE12 uses b2, PE21 uses a2, PE22 uses
  // the passed values of PE21 (a) and PE12 (b).
  // ---------------------------------------------------------------------------
  logic [DW-1:0] pa11, pb11, pa21, pb12;
  logic [AW-1:0] acc11, acc12, acc21, acc22;

  always @(posedge clk) begin
    if (rst) begin
      pa11 <= '0; pb11 <= '0; pa21 <= '0; pb12 <= '0;
      acc11 <= '0; acc12 <= '0; acc21 <= '0; acc22 <= '0;
    end else begin
      acc11 <= (initialize ? AW'(0) : acc11) + AW'(a1)   * AW'(b1);
      acc12 <= (initialize ? AW'(0) : acc12) + AW'(pa11) * AW'(b2);
      acc21 <= (initialize ? AW'(0) : acc21) + AW'(a2)   * AW'(pb11);
      acc22 <= (initialize ? AW'(0) : acc22) + AW'(pa21) * AW'(pb12);
      pa11 <= a1;
      pb11 <= b1;
      pa21 <= a2;
      pb12 <= b2;
    end
  end

  assign c1 = acc11;
  assign c2 = acc12;
  assign c3 = acc21;
  assign c4 = acc22;

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*DW-1:0] m4(input int x00, input int x01,
                                         input int x10, input int x11);
    return {DW'(x11), DW'(x10), DW'(x01), DW'(x00)};
  endfunction

  function automatic logic [4*AW-1:0] r4(input int c11, input int c12,
                                         input int c21, input int c22);
    return {AW'(c22), AW'(c21), AW'(c12), AW'(c11)};
  endfunction

  // Reference: plain 2x2 matrix product, element (i,j) at index 2*i+j.
  function automatic logic [4*AW-1:0] matmul(input logic [4*DW-1:0] a,
                                             input logic [4*DW-1:0] b);
    int ma [2][2];
    int mb [2][2];
    int s;
    logic [4*AW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = int'(a[(2*i+j)*DW +: DW]);
        mb[i][j] = int'(b[(2*i+j)*DW +: DW]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += ma[i][k] * mb[k][j];
        r[(2*i+j)*AW +: AW] = AW'(s);
      end
    return r;
  endfunction

  // Expected {a1,a2,b1,b2,initialize} during FEED step k.
  function automatic logic [4*DW:0] skew_exp(input int k,
                                             input logic [4*DW-1:0] a,
                                             input logic [4*DW-1:0] b);
    logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    {a11, a10, a01, a00} = a;
    {b11, b10, b01, b00} = b;
    case (k)
      0:       return {a00, DW'(0), b00, DW'(0), 1'b1};
      1:       return {a01, a10, b10, b01, 1'b0};
      2:       return {DW'(0), a11, DW'(0), b11, 1'b0};
      default: return '0;
    endcase
  endfunction

  // One complete job: accept, optionally probe the skew, check exact result
  // latency, optionally hold off the result for `hold` cycles, then handshake.
  task automatic run_job(input string tag, input logic [4*DW-1:0] a,
                         input logic [4*DW-1:0] b, input logic [4*AW-1:0] exp,
                         input int hold, input bit probe);
    int n;
    res_ready = (hold == 0);
    a_mat     = a;
    b_mat     = b;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();                         // acceptance edge -> cycle 1
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (probe)
        check($sformatf("%s.feed_k%0d", tag, k),
              64'({a1, a2, b1, b2, initialize}), 64'(skew_exp(k, a, b)));
      check($sformatf("%s.busy_k%0d", tag, k), 64'({busy, in_ready}), 64'b10);
      tick();
    end
    check({tag, ".drain_no_valid"}, 64'(res_valid), 64'd0);
    tick();                         // cycle 6
    check({tag, ".valid_at_6"}, 64'(res_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      check($sformatf("%s.hold%0d", tag, i),
            64'({res_valid, in_ready, busy}), 64'b101);
      check($sformatf("%s.hold_mat%0d", tag, i), 64'(res_mat), 64'(exp));
      in_valid = 1'b1;              // must be ignored outside IDLE
      a_mat    = ~a;
      b_mat    = ~b;
      tick();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    check({tag, ".res_mat"}, 64'(res_mat), 64'(exp));
    tick();                         // handshake edge
    check({tag, ".after_hs"}, 64'({res_valid, in_ready, busy}), 64'b010);
    res_ready = 1'b0;
  endtask

  typedef struct {
    string           tag;
    logic [4*DW-1:0] a;
    logic [4*DW-1:0] b;
    logic [4*AW-1:0] exp;
    int              hold;
    bit              probe;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4*DW-1:0] ra, rb;
    logic [4*DW-1:0] p1a, p1b, p2a, p2b;
    int n;

    vecs[0] = '{"basic",   m4(1, 2, 3, 4),     m4(5, 6, 7, 8),
                r4(19, 22, 43, 50),     0,  1'b1};
    vecs[1] = '{"max",     m4(15, 15, 15, 15), m4(15, 15, 15, 15),
                r4(450, 450, 450, 450), 0,  1'b1};
    vecs[2] = '{"ident",   m4(1, 0, 0, 1),     m4(9, 8, 7, 6),
                r4(9, 8, 7, 6),         0,  1'b0};
    vecs[3] = '{"backpr",  m4(2, 0, 1, 3),     m4(4, 5, 6, 7),
                r4(8, 10, 22, 26),      10, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    a_mat     = '0;
    b_mat     = '0;
    tick();
    tick();
    check("reset.feeds", 64'({a1, a2, b1, b2, initialize}), 64'd0);
    check("reset.flags", 64'({res_valid, in_ready, busy}), 64'b010);
    check("reset.res_mat", 64'(res_mat), 64'd0);
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 4; i++)
      run_job(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp,
              vecs[i].hold, vecs[i].probe);

    // Reset in FEED k=1 abandons the job.
    a_mat    = m4(1, 2, 3, 4);
    b_mat    = m4(5, 6, 7, 8);
    in_valid = 1'b1;
    check("rstjob.ready", 64'(in_ready), 64'd1);
    tick();                         // accepted -> k=0
    in_valid = 1'b0;
    tick();                         // k=1
    check("rstjob.k1_a1", 64'(a1), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstjob.feeds", 64'({a1, a2, b1, b2, initialize}), 64'd0);
    check("rstjob.flags", 64'({res_valid, in_ready, busy}), 64'b010);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid || busy) n++;
    end
    check("rstjob.no_result", 64'(n), 64'd0);
    run_job("post_rst", m4(3, 1, 4, 1), m4(5, 9, 2, 6),
            r4(17, 33, 22, 42), 0, 1'b1);

    // Back-to-back with in_valid held high.
    p1a = m4(7, 3, 2, 9);  p1b = m4(4, 8, 6, 1);
    p2a = m4(11, 0, 5, 13); p2b = m4(2, 14, 10, 3);
    a_mat     = p1a;
    b_mat     = p1b;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    check("b2b.ready1", 64'(in_ready), 64'd1);
    tick();                         // first accepted
    a_mat = p2a;
    b_mat = p2b;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b.blocked%0d", i), 64'(in_ready), 64'd0);
      tick();
    end
    check("b2b.valid1", 64'(res_valid), 64'd1);
    check("b2b.res1", 64'(res_mat), 64'(matmul(p1a, p1b)));
    tick();                         // handshake
    check("b2b.idle_gap", 64'({res_valid, in_ready, busy}), 64'b010);
    tick();                         // second accepted here
    in_valid = 1'b0;
    check("b2b.k0_feed", 64'({a1, a2, b1, b2, initialize}),
          64'(skew_exp(0, p2a, p2b)));
    for (int i = 0; i < 5; i++) tick();
    check("b2b.valid2", 64'(res_valid), 64'd1);
    check("b2b.res2", 64'(res_mat), 64'(matmul(p2a, p2b)));
    tick();
    res_ready = 1'b0;
    check("b2b.done", 64'({res_valid, busy}), 64'b00);

    // Randomized jobs against the matrix-product model.
    for (int i = 0; i < 20; i++) begin
      ra = (4*DW)'($urandom);
      rb = (4*DW)'($urandom);
      run_job($sformatf("rand%0d", i), ra, rb, matmul(ra, rb),
              int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
